// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle reducer and rotation core.
package cordic_pkg;

    localparam int ANGLE_FRAC = 16;

    // Angle constants in Q16, held at the reducer's 21-bit working width.
    localparam logic signed [20:0] TWO_PI_Q16  = 21'sd411775;
    localparam logic signed [20:0] PI_Q16      = 21'sd205887;
    localparam logic signed [20:0] HALF_PI_Q16 = 21'sd102944;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRAP   = 3'd1,
        ST_FOLD   = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4
    } reducer_state_t;

endpackage

// File: rtl/cordic_angle_reducer.sv
// Reduces a Q4.16 angle into [-pi/2, pi/2] for the CORDIC core, launches the
// core, and flags when its sin/cos outputs are valid and whether to negate them.
module cordic_angle_reducer
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [19:0] in_angle,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [17:0] out_angle,
    output logic               init,
    output logic               negate,
    output logic               result_valid
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    reducer_state_t     state_r, state_s;
    logic signed [20:0] acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic signed [17:0] out_angle_r, out_angle_s;
    logic               negate_r, negate_s;
    logic               init_r, init_s;
    logic               in_ready_r, in_ready_s;
    logic               result_valid_r, result_valid_s;

    logic signed [20:0] addend_s;
    logic               adjust_s;
    logic signed [20:0] sum_s;

    // Constant selection for the shared adder: +/-2pi while wrapping, +/-pi while folding.
    always_comb begin
        addend_s = 21'sd0;
        adjust_s = 1'b0;
        if (state_r == ST_WRAP) begin
            if (acc_r > PI_Q16) begin
                addend_s = -TWO_PI_Q16;
                adjust_s = 1'b1;
            end else if (acc_r < -PI_Q16) begin
                addend_s = TWO_PI_Q16;
                adjust_s = 1'b1;
            end else begin
                addend_s = 21'sd0;
                adjust_s = 1'b0;
            end
        end else if (state_r == ST_FOLD) begin
            if (acc_r > HALF_PI_Q16) begin
                addend_s = -PI_Q16;
                adjust_s = 1'b1;
            end else if (acc_r < -HALF_PI_Q16) begin
                addend_s = PI_Q16;
                adjust_s = 1'b1;
            end else begin
                addend_s = 21'sd0;
                adjust_s = 1'b0;
            end
        end else begin
            addend_s = 21'sd0;
            adjust_s = 1'b0;
        end
    end

    assign sum_s = acc_r + addend_s;

    // Next-state and next-output logic; outputs are all registered below.
    always_comb begin
        state_s        = state_r;
        acc_s          = acc_r;
        cnt_s          = cnt_r;
        out_angle_s    = out_angle_r;
        negate_s       = negate_r;
        init_s         = 1'b0;
        in_ready_s     = 1'b0;
        result_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_s      = {in_angle[19], in_angle};
                    state_s    = ST_WRAP;
                    in_ready_s = 1'b0;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            ST_WRAP: begin
                acc_s   = sum_s;
                state_s = ST_FOLD;
            end
            ST_FOLD: begin
                // Result always lies in [-pi/2, pi/2], so 18 bits suffice.
                out_angle_s = sum_s[17:0];
                negate_s    = adjust_s;
                init_s      = 1'b1;
                state_s     = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                cnt_s   = CNT_ZERO;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    result_valid_s = 1'b1;
                    in_ready_s     = 1'b1;
                    state_s        = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                in_ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset that drops any pending angle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            acc_r          <= 21'sd0;
            cnt_r          <= CNT_ZERO;
            out_angle_r    <= 18'sd0;
            negate_r       <= 1'b0;
            init_r         <= 1'b0;
            in_ready_r     <= 1'b1;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            acc_r          <= acc_s;
            cnt_r          <= cnt_s;
            out_angle_r    <= out_angle_s;
            negate_r       <= negate_s;
            init_r         <= init_s;
            in_ready_r     <= in_ready_s;
            result_valid_r <= result_valid_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_angle    = out_angle_r;
    assign init         = init_r;
    assign negate       = negate_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed self-checking bench for cordic_angle_reducer.
module tb_cordic_angle_reducer;

    localparam int ITER = 16;

    logic               clock;
    logic               reset;
    logic signed [19:0] in_angle;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] out_angle;
    logic               init;
    logic               negate;
    logic               result_valid;

    int total = 0;
    int bad   = 0;

    cordic_angle_reducer #(.ITERATIONS(ITER)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_angle     (in_angle),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_angle    (out_angle),
        .init         (init),
        .negate       (negate),
        .result_valid (result_valid)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feed one angle and follow it through to result_valid.
    task automatic run_angle(input string tag, input int ang, input int exp_out, input int exp_neg);
        int seen;
        int drift;
        seen  = 0;
        drift = 0;
        @(negedge clock);
        in_angle = 20'(ang);
        in_valid = 1'b1;
        check({tag, ".ready"}, in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check({tag, ".init_e0"}, init, 0);
        for (int n = 1; n <= 30 && seen == 0; n++) begin
            @(posedge clock);
            #1;
            if (n == 1) check({tag, ".init_e1"}, init, 0);
            if (n == 2) begin
                check({tag, ".init_e2"}, init, 1);
                check({tag, ".out_fold"}, out_angle, exp_out);
                check({tag, ".neg_fold"}, negate, exp_neg);
            end
            if (n == 3) check({tag, ".init_e3"}, init, 0);
            if (n > 2 && (out_angle !== 18'(exp_out) || negate !== 1'(exp_neg))) drift++;
            if (result_valid === 1'b1) seen = n;
        end
        check({tag, ".latency"}, seen, ITER + 3);
        check({tag, ".drift"}, drift, 0);
        check({tag, ".out_rv"}, out_angle, exp_out);
        check({tag, ".neg_rv"}, negate, exp_neg);
        check({tag, ".ready_rv"}, in_ready, 1);
        @(posedge clock);
        #1;
        check({tag, ".rv_pulse"}, result_valid, 0);
    endtask

    initial begin
        int ready_cnt;
        int ready_pos [3];
        int pulses;
        int waited;

        reset    = 1'b1;
        in_valid = 1'b1;
        in_angle = 20'sd19661;
        repeat (2) @(posedge clock);
        #1;
        check("rst.ready", in_ready, 1);
        check("rst.init", init, 0);
        check("rst.out", out_angle, 0);
        check("rst.neg", negate, 0);
        check("rst.rv", result_valid, 0);

        // in_valid held with reset must not start anything.
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        pulses   = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (init === 1'b1 || in_ready !== 1'b1) pulses++;
        end
        check("rst.valid_ignored", pulses, 0);

        run_angle("a0p3",   19661,   19661,   0);
        run_angle("a3p0",   196608,  -9279,   1);
        run_angle("a7p0",   458752,  46977,   0);
        run_angle("am8",    -524288, 93374,   1);
        run_angle("api",    205887,  0,       1);
        run_angle("amhpi",  -102944, -102944, 0);
        run_angle("ahpi",   102944,  102944,  0);

        // Back-pressure: in_valid held high, accepts spaced ITER+4 apart.
        ready_cnt = 0;
        @(negedge clock);
        in_angle = 20'sd196608;
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (in_ready === 1'b1) begin
                if (ready_cnt < 3) ready_pos[ready_cnt] = i;
                ready_cnt++;
            end
            if (i > 3 && in_ready === 1'b0 && out_angle !== -18'sd9279) ready_cnt += 100;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("bp.count", ready_cnt, 3);
        check("bp.gap1", ready_pos[1] - ready_pos[0], ITER + 4);
        check("bp.gap2", ready_pos[2] - ready_pos[1], ITER + 4);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("bp.drain", in_ready, 1);

        // Reset in the middle of WAIT discards the angle.
        @(negedge clock);
        in_angle = 20'sd458752;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid.ready", in_ready, 1);
        check("mid.init", init, 0);
        check("mid.rv", result_valid, 0);
        check("mid.out", out_angle, 0);
        check("mid.neg", negate, 0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (init === 1'b1 || result_valid === 1'b1) pulses++;
        end
        check("mid.no_pulse", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
